// File: rtl/fetch_sequencer.sv
// Program-counter and fetch-control stage feeding a 1-cycle-latency instruction ROM.
// Tags each ROM word with its PC and a valid bit; handles stall, redirect, halt and resume.
module fetch_sequencer #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt,
    input  logic                resume,
    output logic [PC_WIDTH-1:0] rom_addr,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic                fetch_valid,
    output logic                halted,
    output logic [31:0]         instr_count
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                fv_q, fv_d;
    logic                halted_q, halted_d;
    logic [31:0]         count_q, count_d;
    logic [PC_WIDTH-1:0] rom_addr_s;
    logic                fetch_valid_s;

    // A redirect squashes the wrong-path word currently on instr.
    assign fetch_valid_s = fv_q & ~redirect;

    // Next-state, ROM address and accept counting.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        fv_d       = fv_q;
        rom_addr_s = pc_q;

        if (fetch_valid_s && !stall) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end

        case (state_q)
            ST_BOOT: begin
                fetch_pc_d = pc_q;
                fv_d       = 1'b1;
                pc_d       = pc_q + PC_ONE;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    rom_addr_s = redirect_pc;
                    fetch_pc_d = redirect_pc;
                    fv_d       = 1'b1;
                    pc_d       = redirect_pc + PC_ONE;
                end else if (halt) begin
                    // pc_q already points past the HLT, so resume continues after it.
                    fv_d    = 1'b0;
                    state_d = ST_HALTED;
                end else if (stall) begin
                    // Re-read the held address so instr stays stable.
                    rom_addr_s = fetch_pc_q;
                end else begin
                    fetch_pc_d = pc_q;
                    fv_d       = 1'b1;
                    pc_d       = pc_q + PC_ONE;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    fetch_pc_d = pc_q;
                    fv_d       = 1'b1;
                    pc_d       = pc_q + PC_ONE;
                    state_d    = ST_RUN;
                end else begin
                    fv_d    = 1'b0;
                    state_d = ST_HALTED;
                end
            end
            default: begin
                fv_d    = 1'b0;
                state_d = ST_BOOT;
            end
        endcase

        halted_d = (state_d == ST_HALTED);
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            fetch_pc_q <= {PC_WIDTH{1'b0}};
            fv_q       <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            fv_q       <= fv_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    assign rom_addr    = rom_addr_s;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_valid = fetch_valid_s;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule
